// File: rtl/cpu_mc.sv
// Multi-cycle RV32I/RV32E core: FETCH -> EXEC -> (MEM) -> FETCH over valid/ready
// instruction and data ports, halting in a sticky TRAP state on faults.
module cpu_mc #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NREGS    = 32,
    parameter int          XLEN     = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_valid,
    input  logic        imem_ready,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        dmem_valid,
    input  logic        dmem_ready,
    output logic        dmem_we,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [31:0] trap_pc
);
    if (XLEN != 32) begin : g_xlen_check
        $error("cpu_mc supports XLEN = 32 only");
    end

    localparam int          AW      = $clog2(NREGS);
    localparam logic [5:0]  NREGS_W = 6'(NREGS);
    localparam logic [6:0]  OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                            OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011,
                            OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_REG = 7'b0110011,
                            OP_FENCE = 7'b0001111, OP_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_TRAP} state_t;

    state_t      state_r;
    logic [31:0] pc_r, ir_r, ea_r;
    logic [31:0] regs_r [NREGS];
    logic        imem_valid_r, dmem_valid_r, dmem_we_r, trap_r;
    logic [3:0]  dmem_be_r;
    logic [31:0] dmem_addr_r, dmem_wdata_r, trap_pc_r;
    logic [1:0]  trap_cause_r;

    function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (f3)
            3'b000:  r = alt ? (a - b) : (a + b);
            3'b001:  r = a << b[4:0];
            3'b010:  r = {31'd0, $signed(a) < $signed(b)};
            3'b011:  r = {31'd0, a < b};
            3'b100:  r = a ^ b;
            3'b101:  if (alt) r = $signed(a) >>> b[4:0]; else r = a >> b[4:0];
            3'b110:  r = a | b;
            3'b111:  r = a & b;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] word);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (f3)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b100:  return {24'd0, sh[7:0]};
            3'b101:  return {16'd0, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    logic [6:0]  opcode_s, f7_s;
    logic [4:0]  rd_s, rs1_s, rs2_s;
    logic [2:0]  f3_s;
    logic [31:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s, rs1_val_s, rs2_val_s, pc_plus4_s;
    assign opcode_s   = ir_r[6:0];
    assign rd_s       = ir_r[11:7];
    assign f3_s       = ir_r[14:12];
    assign rs1_s      = ir_r[19:15];
    assign rs2_s      = ir_r[24:20];
    assign f7_s       = ir_r[31:25];
    assign imm_i_s    = {{20{ir_r[31]}}, ir_r[31:20]};
    assign imm_s_s    = {{20{ir_r[31]}}, ir_r[31:25], ir_r[11:7]};
    assign imm_b_s    = {{19{ir_r[31]}}, ir_r[31], ir_r[7], ir_r[30:25], ir_r[11:8], 1'b0};
    assign imm_u_s    = {ir_r[31:12], 12'd0};
    assign imm_j_s    = {{11{ir_r[31]}}, ir_r[31], ir_r[19:12], ir_r[20], ir_r[30:21], 1'b0};
    assign rs1_val_s  = (rs1_s == 5'd0) ? 32'd0 : regs_r[rs1_s[AW-1:0]];
    assign rs2_val_s  = (rs2_s == 5'd0) ? 32'd0 : regs_r[rs2_s[AW-1:0]];
    assign pc_plus4_s = pc_r + 32'd4;

    logic        illegal_s, env_s, mis_pc_s, mis_d_s, bad_reg_s, trap_s, to_mem_s, taken_s, wen_s;
    logic        use_rs1_s, use_rs2_s, use_rd_s, alt_s;
    logic [1:0]  cause_s;
    logic [31:0] next_pc_s, target_s, ea_s, wval_s, st_data_s;
    logic [3:0]  be_s;

    // EXEC decode: next pc, rd write value, memory request and trap classification
    always_comb begin
        illegal_s = 1'b0; env_s = 1'b0; mis_pc_s = 1'b0; to_mem_s = 1'b0; taken_s = 1'b0;
        wen_s = 1'b0; use_rs1_s = 1'b0; use_rs2_s = 1'b0; use_rd_s = 1'b0;
        next_pc_s = pc_plus4_s; target_s = 32'd0; ea_s = 32'd0; wval_s = 32'd0;
        alt_s = (opcode_s == OP_REG) ? ir_r[30] : ((f3_s == 3'b101) && ir_r[30]);
        case (opcode_s)
            OP_LUI:   begin use_rd_s = 1'b1; wen_s = 1'b1; wval_s = imm_u_s; end
            OP_AUIPC: begin use_rd_s = 1'b1; wen_s = 1'b1; wval_s = pc_r + imm_u_s; end
            OP_IMM: begin
                use_rd_s = 1'b1; use_rs1_s = 1'b1; wen_s = 1'b1;
                wval_s = alu(f3_s, alt_s, rs1_val_s, imm_i_s);
                illegal_s = ((f3_s == 3'b001) && (f7_s != 7'd0)) ||
                            ((f3_s == 3'b101) && (f7_s != 7'd0) && (f7_s != 7'b0100000));
            end
            OP_REG: begin
                use_rd_s = 1'b1; use_rs1_s = 1'b1; use_rs2_s = 1'b1; wen_s = 1'b1;
                wval_s = alu(f3_s, alt_s, rs1_val_s, rs2_val_s);
                illegal_s = !((f7_s == 7'd0) ||
                              ((f7_s == 7'b0100000) && ((f3_s == 3'b000) || (f3_s == 3'b101))));
            end
            OP_BRANCH: begin
                use_rs1_s = 1'b1; use_rs2_s = 1'b1;
                illegal_s = (f3_s[2:1] == 2'b01);
                case (f3_s)
                    3'b000:  taken_s = (rs1_val_s == rs2_val_s);
                    3'b001:  taken_s = (rs1_val_s != rs2_val_s);
                    3'b100:  taken_s = ($signed(rs1_val_s) < $signed(rs2_val_s));
                    3'b101:  taken_s = ($signed(rs1_val_s) >= $signed(rs2_val_s));
                    3'b110:  taken_s = (rs1_val_s < rs2_val_s);
                    3'b111:  taken_s = (rs1_val_s >= rs2_val_s);
                    default: taken_s = 1'b0;
                endcase
                target_s  = pc_r + imm_b_s;
                next_pc_s = taken_s ? target_s : pc_plus4_s;
                mis_pc_s  = taken_s && (target_s[1:0] != 2'b00);
            end
            OP_JAL, OP_JALR: begin
                use_rd_s = 1'b1; use_rs1_s = (opcode_s == OP_JALR); wen_s = 1'b1;
                illegal_s = (opcode_s == OP_JALR) && (f3_s != 3'b000);
                target_s  = (opcode_s == OP_JAL) ? (pc_r + imm_j_s)
                                                 : ((rs1_val_s + imm_i_s) & ~32'd1);
                next_pc_s = target_s;
                wval_s    = pc_plus4_s;
                mis_pc_s  = (target_s[1:0] != 2'b00);
            end
            OP_LOAD: begin
                use_rd_s = 1'b1; use_rs1_s = 1'b1; to_mem_s = 1'b1;
                ea_s = rs1_val_s + imm_i_s;
                illegal_s = (f3_s == 3'b011) || (f3_s[2:1] == 2'b11);
            end
            OP_STORE: begin
                use_rs1_s = 1'b1; use_rs2_s = 1'b1; to_mem_s = 1'b1;
                ea_s = rs1_val_s + imm_s_s;
                illegal_s = (f3_s[2] == 1'b1) || (f3_s[1:0] == 2'b11);
            end
            OP_FENCE: begin illegal_s = 1'b0; end
            OP_SYSTEM: begin
                env_s     = (ir_r == 32'h0000_0073) || (ir_r == 32'h0010_0073);
                illegal_s = !env_s;
            end
            default: illegal_s = 1'b1;
        endcase
    end

    assign mis_d_s   = to_mem_s && (((f3_s[1:0] == 2'b01) && ea_s[0]) ||
                                    ((f3_s[1:0] == 2'b10) && (ea_s[1:0] != 2'b00)));
    assign bad_reg_s = (use_rs1_s && ({1'b0, rs1_s} >= NREGS_W)) ||
                       (use_rs2_s && ({1'b0, rs2_s} >= NREGS_W)) ||
                       (use_rd_s  && ({1'b0, rd_s}  >= NREGS_W));
    assign trap_s    = illegal_s || bad_reg_s || env_s || mis_pc_s || mis_d_s;
    assign cause_s   = (illegal_s || bad_reg_s) ? 2'd1 : env_s ? 2'd0 : mis_pc_s ? 2'd2 : 2'd3;

    // Store lane placement: byte/half replicated across the word, enables at ea[1:0]
    always_comb begin
        case (f3_s[1:0])
            2'b00:   begin be_s = 4'b0001 << ea_s[1:0]; st_data_s = {4{rs2_val_s[7:0]}}; end
            2'b01:   begin be_s = 4'b0011 << ea_s[1:0]; st_data_s = {2{rs2_val_s[15:0]}}; end
            default: begin be_s = 4'b1111;              st_data_s = rs2_val_s; end
        endcase
    end

    logic        rf_we_s, load_done_s;
    logic [31:0] rf_wdata_s;
    assign load_done_s = (state_r == S_MEM) && dmem_ready && !dmem_we_r;
    assign rf_we_s     = ((state_r == S_EXEC) && wen_s && !trap_s) || load_done_s;
    assign rf_wdata_s  = load_done_s ? load_ext(f3_s, ea_r[1:0], dmem_rdata) : wval_s;

    // Register file (not reset); writes to x0 are dropped
    always_ff @(posedge clk) begin
        if (rf_we_s && (rd_s != 5'd0)) begin
            regs_r[rd_s[AW-1:0]] <= rf_wdata_s;
        end
    end

    // Control FSM with registered bus and trap outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_FETCH; pc_r <= RESET_PC; ir_r <= 32'd0; ea_r <= 32'd0;
            imem_valid_r <= 1'b0; dmem_valid_r <= 1'b0; dmem_we_r <= 1'b0; dmem_be_r <= 4'd0;
            dmem_addr_r <= 32'd0; dmem_wdata_r <= 32'd0;
            trap_r <= 1'b0; trap_cause_r <= 2'd0; trap_pc_r <= 32'd0;
        end else begin
            case (state_r)
                S_FETCH: begin
                    if (imem_valid_r && imem_ready) begin
                        ir_r <= imem_rdata; imem_valid_r <= 1'b0; state_r <= S_EXEC;
                    end else begin
                        imem_valid_r <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (trap_s) begin
                        state_r <= S_TRAP; trap_r <= 1'b1; trap_cause_r <= cause_s; trap_pc_r <= pc_r;
                    end else if (to_mem_s) begin
                        state_r <= S_MEM; dmem_valid_r <= 1'b1; ea_r <= ea_s;
                        dmem_we_r <= (opcode_s == OP_STORE); dmem_be_r <= be_s;
                        dmem_addr_r <= {ea_s[31:2], 2'b00}; dmem_wdata_r <= st_data_s;
                    end else begin
                        pc_r <= next_pc_s; imem_valid_r <= 1'b1; state_r <= S_FETCH;
                    end
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        dmem_valid_r <= 1'b0; dmem_we_r <= 1'b0; dmem_be_r <= 4'd0;
                        pc_r <= pc_plus4_s; imem_valid_r <= 1'b1; state_r <= S_FETCH;
                    end
                end
                S_TRAP:  state_r <= S_TRAP;
                default: state_r <= S_TRAP;
            endcase
        end
    end

    assign imem_valid = imem_valid_r;
    assign imem_addr  = pc_r;
    assign dmem_valid = dmem_valid_r;
    assign dmem_we    = dmem_we_r;
    assign dmem_be    = dmem_be_r;
    assign dmem_addr  = dmem_addr_r;
    assign dmem_wdata = dmem_wdata_r;
    assign trap       = trap_r;
    assign trap_cause = trap_cause_r;
    assign trap_pc    = trap_pc_r;
endmodule

// File: tb/tb_cpu_mc.sv
// Scoreboard bench for cpu_mc: small programs in an instruction ROM, expected data-port
// transactions queued up front and compared on each dmem handshake.
module tb_cpu_mc;
    localparam logic [31:0] RPC = 32'h0000_0100;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        imem_valid, imem_ready, dmem_valid, dmem_ready, dmem_we, trap;
    logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, trap_pc;
    logic [3:0]  dmem_be;
    logic [1:0]  trap_cause;
    logic        i_rdy = 1'b1, d_rdy = 1'b1;
    logic [31:0] d_rdata = 32'd0;
    logic [31:0] imem_mem [0:63];

    assign imem_ready = i_rdy;
    assign imem_rdata = imem_mem[imem_addr[7:2]];
    assign dmem_ready = d_rdy;
    assign dmem_rdata = d_rdata;

    cpu_mc #(.RESET_PC(RPC), .NREGS(16), .XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_valid(imem_valid), .imem_ready(imem_ready), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .dmem_valid(dmem_valid), .dmem_ready(dmem_ready), .dmem_we(dmem_we), .dmem_be(dmem_be),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .trap(trap), .trap_cause(trap_cause), .trap_pc(trap_pc)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {logic we; logic [3:0] be; logic [31:0] addr; logic [31:0] wdata;} dtx_t;
    dtx_t        exp_q[$];
    logic [31:0] prog[$];
    int          fetch_cyc[$];
    logic [31:0] fetch_addr[$];
    int          store_cyc = 0;
    bit          saw_dvalid = 1'b0;
    int          n_vec = 0, n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, int op);
        logic [31:0] t;
        t = imm;
        return {t[11:0], 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
    endfunction
    function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
        logic [31:0] t;
        t = imm;
        return {t[11:5], 5'(rs2), 5'(rs1), 3'(f3), t[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
        logic [31:0] t;
        t = imm;
        return {t[12], t[10:5], 5'(rs2), 5'(rs1), 3'(f3), t[4:1], t[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
    endfunction
    function automatic logic [31:0] enc_j(int imm, int rd);
        logic [31:0] t;
        t = imm;
        return {t[20], t[10:1], t[11], t[19:12], 5'(rd), 7'h6F};
    endfunction
    function automatic logic [31:0] addi(int rd, int rs1, int imm);
        return enc_i(imm, rs1, 0, rd, 'h13);
    endfunction

    task automatic exp_st(logic [31:0] addr, logic [3:0] be, logic [31:0] wdata);
        exp_q.push_back({1'b1, be, addr, wdata});
    endtask
    task automatic exp_ld(logic [31:0] addr);
        exp_q.push_back({1'b0, 4'h0, addr, 32'h0});
    endtask

    // Data-port scoreboard and fetch logger, sampled mid-cycle
    always @(negedge clk) begin : mon
        dtx_t e;
        if (rst_n) begin
            if (imem_valid && imem_ready) begin
                fetch_cyc.push_back(cyc);
                fetch_addr.push_back(imem_addr);
            end
            if (dmem_valid) saw_dvalid = 1'b1;
            if (dmem_valid && dmem_ready) begin
                if (exp_q.size() == 0) begin
                    check("dmem_extra_tx", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("dmem_we", 32'(dmem_we), 32'(e.we));
                    check("dmem_addr", dmem_addr, e.addr);
                    if (e.we) begin
                        check("dmem_be", 32'(dmem_be), 32'(e.be));
                        check("dmem_wdata", dmem_wdata, e.wdata);
                    end
                    store_cyc = cyc;
                end
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0; i_rdy = 1'b1; d_rdy = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        fetch_cyc.delete(); fetch_addr.delete(); exp_q.delete();
        saw_dvalid = 1'b0;
        for (int i = 0; i < 64; i++) imem_mem[i] = (i < prog.size()) ? prog[i] : 32'h0;
        prog.delete();
    endtask

    task automatic wait_trap(input string tag, input int cause, input logic [31:0] tpc);
        int n = 0;
        while (!trap && n < 300) begin @(posedge clk); #1; n++; end
        check({tag, "_trap"}, 32'(trap), 32'd1);
        check({tag, "_cause"}, 32'(trap_cause), 32'(cause));
        check({tag, "_trap_pc"}, trap_pc, tpc);
        check({tag, "_sb_left"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t0, first1, store1, n;
        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_imem_valid", 32'(imem_valid), 32'd0);
        check("rst_dmem_valid", 32'(dmem_valid), 32'd0);
        check("rst_dmem_we", 32'(dmem_we), 32'd0);
        check("rst_dmem_be", 32'(dmem_be), 32'd0);
        check("rst_trap", 32'(trap), 32'd0);
        check("rst_trap_cause", 32'(trap_cause), 32'd0);
        check("rst_trap_pc", trap_pc, 32'd0);
        check("rst_pc", imem_addr, RPC);

        // ADDI chain, zero-wait fetch timing
        prog = '{addi(1, 0, 5), addi(2, 1, -7), addi(3, 0, 'h200), addi(2, 2, 0),
                 enc_s(0, 2, 3, 2), 32'h0010_0073};
        do_reset();
        exp_st(32'h200, 4'hF, 32'hFFFF_FFFE);
        rst_n = 1'b1; t0 = cyc;
        wait_trap("addi", 0, 32'h114);
        check("first_fetch_addr", fetch_addr[0], RPC);
        for (int i = 1; i < 5; i++) check("alu_fetch_gap", 32'(fetch_cyc[i] - fetch_cyc[i-1]), 32'd2);
        check("store_fetch_gap", 32'(fetch_cyc[5] - fetch_cyc[4]), 32'd3);
        first1 = fetch_cyc[0] - t0;
        store1 = store_cyc - t0;

        // Same program with imem_ready low for the first 3 requested cycles
        prog = '{addi(1, 0, 5), addi(2, 1, -7), addi(3, 0, 'h200), addi(2, 2, 0),
                 enc_s(0, 2, 3, 2), 32'h0010_0073};
        do_reset();
        exp_st(32'h200, 4'hF, 32'hFFFF_FFFE);
        i_rdy = 1'b0; rst_n = 1'b1; t0 = cyc;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            check("stall_imem_valid", 32'(imem_valid), 32'd1);
            check("stall_imem_addr", imem_addr, RPC);
            @(posedge clk); #1;
        end
        i_rdy = 1'b1;
        wait_trap("stall", 0, 32'h114);
        check("stall_fetch_delay", 32'(fetch_cyc[0] - t0), 32'(first1 + 3));
        check("stall_store_delay", 32'(store_cyc - t0), 32'(store1 + 3));

        // Byte/half stores and sign/zero-extending loads
        prog = '{addi(1, 0, 'h200), addi(2, 0, 'hA5), enc_s(3, 2, 1, 0), enc_s(2, 2, 1, 1),
                 enc_i(3, 1, 0, 3, 'h03), enc_i(3, 1, 4, 4, 'h03), enc_s(0, 3, 1, 2),
                 enc_s(4, 4, 1, 2), enc_i(2, 1, 1, 5, 'h03), enc_s(8, 5, 1, 2), 32'h0010_0073};
        do_reset();
        d_rdata = 32'hA500_0000;
        exp_st(32'h200, 4'b1000, 32'hA5A5_A5A5);
        exp_st(32'h200, 4'b1100, 32'h00A5_00A5);
        exp_ld(32'h200); exp_ld(32'h200);
        exp_st(32'h200, 4'hF, 32'hFFFF_FFA5);
        exp_st(32'h204, 4'hF, 32'h0000_00A5);
        exp_ld(32'h200);
        exp_st(32'h208, 4'hF, 32'hFFFF_A500);
        rst_n = 1'b1;
        wait_trap("bytes", 0, 32'h128);

        // Signed/unsigned branches, shifts, SUB, JAL
        prog = '{addi(1, 0, -1), addi(2, 0, 1), addi(3, 0, 'h200), enc_b(8, 2, 1, 4),
                 enc_s(0, 1, 3, 2), enc_b(8, 2, 1, 6), enc_s(4, 2, 3, 2),
                 {20'h80000, 5'd4, 7'h37}, enc_i('h404, 4, 5, 5, 'h13), enc_i(4, 4, 5, 6, 'h13),
                 enc_s(8, 5, 3, 2), enc_s(12, 6, 3, 2), enc_r('h20, 1, 2, 0, 7),
                 enc_r('h20, 2, 4, 5, 8), enc_s(16, 7, 3, 2), enc_s(20, 8, 3, 2),
                 enc_j(8, 9), enc_s(0, 0, 3, 2), enc_s(24, 9, 3, 2), 32'h0010_0073};
        do_reset();
        exp_st(32'h204, 4'hF, 32'h0000_0001);
        exp_st(32'h208, 4'hF, 32'hF800_0000);
        exp_st(32'h20C, 4'hF, 32'h0800_0000);
        exp_st(32'h210, 4'hF, 32'h0000_0002);
        exp_st(32'h214, 4'hF, 32'hC000_0000);
        exp_st(32'h218, 4'hF, 32'h0000_0144);
        rst_n = 1'b1;
        wait_trap("branch", 0, 32'h14C);

        // Misaligned LW: trap 3, no data access, no further fetches
        prog = '{addi(1, 0, 'h200), enc_i(2, 1, 2, 2, 'h03)};
        do_reset();
        rst_n = 1'b1;
        wait_trap("lw_mis", 3, 32'h104);
        repeat (10) @(posedge clk);
        #1;
        check("lw_mis_no_dvalid", 32'(saw_dvalid), 32'd0);
        check("lw_mis_imem_valid", 32'(imem_valid), 32'd0);
        check("lw_mis_fetches", 32'(fetch_cyc.size()), 32'd2);

        // Illegal register index (NREGS=16), illegal opcode, ECALL
        prog = '{enc_r(0, 2, 1, 0, 17)};
        do_reset(); rst_n = 1'b1;
        wait_trap("x17", 1, 32'h100);
        prog = '{addi(1, 0, 1), 32'h0000_007F};
        do_reset(); rst_n = 1'b1;
        wait_trap("op7f", 1, 32'h104);
        prog = '{addi(1, 0, 1), addi(1, 0, 2), 32'h0000_0073};
        do_reset(); rst_n = 1'b1;
        wait_trap("ecall", 0, 32'h108);

        // JALR to misaligned target leaves rd alone; register file survives reset
        prog = '{addi(5, 0, 'h55), addi(1, 0, 'h203), enc_i(0, 1, 0, 5, 'h67)};
        do_reset(); rst_n = 1'b1;
        wait_trap("jalr_mis", 2, 32'h108);
        prog = '{addi(3, 0, 'h200), enc_s(0, 5, 3, 2), 32'h0010_0073};
        do_reset();
        exp_st(32'h200, 4'hF, 32'h0000_0055);
        rst_n = 1'b1;
        wait_trap("jalr_rd", 0, 32'h108);

        // Stalled store held stable, then reset mid-request drops valid at once
        prog = '{addi(1, 0, 'h200), enc_s(1, 1, 1, 0)};
        do_reset();
        d_rdy = 1'b0; rst_n = 1'b1;
        n = 0;
        while (!dmem_valid && n < 50) begin @(posedge clk); #1; n++; end
        check("hold_dvalid", 32'(dmem_valid), 32'd1);
        repeat (2) begin
            @(posedge clk); #1;
            check("hold_daddr", dmem_addr, 32'h200);
            check("hold_dbe", 32'(dmem_be), 32'b0010);
            check("hold_dwdata", dmem_wdata, 32'h0000_0000);
        end
        #2 rst_n = 1'b0;
        #1;
        check("midrst_dvalid", 32'(dmem_valid), 32'd0);
        check("midrst_dwe", 32'(dmem_we), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/cpu_mc.md
Name: cpu_mc

Overview:
- Parametrised multi-cycle RV32I/RV32E core, successor to the single-state-machine core.
- Fetches over a valid/ready instruction port and loads/stores over a valid/ready data port with byte enables, so no read-modify-write is needed.
- Adds a configurable reset vector and register-file size.
- Raises a sticky trap on illegal, misaligned or environment instructions.
- Sits between the testbench/SoC memory models and nothing else; top-level CPU.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded at reset
NREGS, 32, architectural register count; 32 = RV32I, 16 = RV32E
XLEN, 32, data width; only 32 supported, elaborate-time error otherwise

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
imem_valid  out  1  fetch request
imem_ready  in  1  fetch accepted, imem_rdata valid this cycle
imem_addr  out  32  fetch address (= pc)
imem_rdata  in  32  instruction word
dmem_valid  out  1  data request
dmem_ready  in  1  data accepted; for loads dmem_rdata valid this cycle
dmem_we  out  1  1 = store
dmem_be  out  4  byte enables
dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
dmem_wdata  out  32  store data, lane-replicated
dmem_rdata  in  32  load data word
trap  out  1  sticky halt indicator
trap_cause  out  2  0 ECALL/EBREAK, 1 illegal, 2 instr misaligned, 3 data misaligned
trap_pc  out  32  pc of faulting instruction

Behaviour:
- Reset (async):
  - pc = RESET_PC, state = FETCH.
  - All valid/we/be outputs 0; trap = 0, trap_cause = 0, trap_pc = 0.
  - Register file is not reset; x0 always reads 0 and writes to it are dropped.
- FETCH:
  - imem_valid = 1 and imem_addr = pc.
  - On imem_valid & imem_ready: latch imem_rdata into ir, go to EXEC.
  - Otherwise hold; imem_addr stays stable while waiting.
- EXEC (1 cycle): decode ir.
  - ALU/LUI/AUIPC: write rd, pc += 4, go to FETCH.
  - Branches:
    - BLT/BGE signed compare; BLTU/BGEU unsigned compare.
    - Taken target = pc + b_imm. Target[1:0] != 0 -> TRAP cause 2; otherwise pc = target.
    - Not taken: pc += 4.
  - JAL/JALR:
    - JAL target = pc + j_imm; JALR target = (rs1 + i_imm) & ~1.
    - Misaligned target (bit 1 set) -> TRAP cause 2, no rd write.
    - Otherwise rd = pc + 4, pc = target.
  - Shifts: amount = imm[4:0] or rs2[4:0].
    - SRA/SRAI sign-fill; f7 = 0100000 selects SRA/SUB.
    - Any other f7 on shift/add = illegal.
  - FENCE: nop.
  - ECALL/EBREAK: TRAP cause 0.
  - Illegal (cause 1):
    - unknown opcode, f3 or f7;
    - any rs1/rs2/rd index >= NREGS;
    - ir[1:0] != 2'b11.
  - Load/store: ea = rs1 + imm (I-imm for loads, S-imm for stores).
    - Misaligned (LH/LHU/SH ea[0] != 0; LW/SW ea[1:0] != 0) -> TRAP cause 3, no bus access.
    - Otherwise go to MEM.
- MEM:
  - dmem_valid = 1; addr/we/be/wdata held stable until dmem_ready.
  - Byte enables: SB be = 1 << ea[1:0]; SH be = 2'b11 << ea[1:0]; SW be = 4'hF.
  - wdata: byte replicated x4, half replicated x2, word as is.
  - Loads extract the lane at ea[1:0] and sign/zero-extend per f3.
  - On the handshake: write rd (loads), pc += 4, go to FETCH.
- TRAP:
  - trap = 1, trap_cause set, trap_pc = faulting pc.
  - Core halts; no further requests and no architectural state change until reset.
- Latency with zero-wait memory: ALU/branch/jump 2 cycles; load/store 3 cycles. Each wait cycle on ready adds 1.
- Arithmetic: all mod 2^32; pc wraps from 32'hFFFF_FFFC to 0 without trap.
- Rd == rs1 is legal: operands are read in EXEC before the register write.
- Reset asserted mid-request drops valid immediately; no transaction is completed.

Test Plan:
- RESET_PC=32'h100, ready held 1 -> first imem_addr = 32'h100; 4-instruction ADDI chain (x1=5, x2=x1+(-7)) gives x2 = 32'hFFFF_FFFE; pc advances by 4 every 2 cycles.
- imem_ready low for 3 cycles -> imem_valid held, imem_addr stable, no register write; instruction completes exactly 3 cycles late.
- x1=32'h200, x2=32'hA5: SB x2,3(x1) -> dmem_addr = 32'h200, be = 4'b1000, wdata = 32'hA5A5_A5A5. Then LB x3,3(x1) with rdata = 32'hA500_0000 -> x3 = 32'hFFFF_FFA5; LBU -> 32'h0000_00A5.
- x1 = 32'hFFFF_FFFF, x2 = 1:
  - BLT x1,x2,+8 is taken; BLTU is not taken.
  - SRA by 4 of 32'h8000_0000 gives 32'hF800_0000.
  - SRL by 4 gives 32'h0800_0000.
- LW at ea = 32'h202 -> trap = 1, cause = 3, trap_pc = pc of the LW, dmem_valid never asserted; afterwards imem_valid stays 0.
- NREGS=16: ADD x17,x1,x2 -> trap cause 1. Opcode 7'b1111111 -> cause 1. EBREAK -> cause 0. JALR to odd+2 target -> cause 2, rd unchanged.
